// File: rtl/fifo_sample_reader.sv
// -----------------------------------------------------------------------------
// fifo_sample_reader
//
// Read-side consumer of the function generator's sample FIFO. When streaming is
// enabled and the FIFO holds data, one sample is popped per frame. Each sample
// is shifted MSB-first onto a 3-wire DAC link (cs_n_o / sclk_o / sdo_o). An
// empty FIFO at the end of a frame while streaming is flagged as an underrun.
//
// Build option:
//   FIFO_READER_OFFSET_BIN_EN - when defined, the sample MSB is inverted on
//                               load (two's complement -> offset binary).
//
// Parameters:
//   DATA_WIDTH - sample width, equal to the FIFO data width (>= 2)
//   CLK_DIV    - system clocks per serial bit, even and >= 2
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-low reset
//   en_i       in   streaming enable
//   empty_i    in   FIFO empty flag
//   data_i     in   FIFO read data, valid the cycle after rd_en_o
//   rd_en_o    out  FIFO pop strobe, one-cycle pulse
//   cs_n_o     out  DAC chip select, active low
//   sclk_o     out  DAC serial clock
//   sdo_o      out  DAC serial data
//   busy_o     out  high whenever the FSM is not idle
//   underrun_o out  sticky underrun flag, cleared when en_i is sampled low
// -----------------------------------------------------------------------------
module fifo_sample_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en_i,
    input  logic                         empty_i,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    output logic                         rd_en_o,
    output logic                         cs_n_o,
    output logic                         sclk_o,
    output logic                         sdo_o,
    output logic                         busy_o,
    output logic                         underrun_o
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LATCH = 3'd2,
        ST_SHIFT = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t                 state_r;
    logic [DATA_WIDTH-1:0]  shift_r;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic [DIV_W-1:0]       div_r;
    logic                   rd_en_r;
    logic                   cs_n_r;
    logic                   sclk_r;
    logic                   sdo_r;
    logic                   busy_r;
    logic                   underrun_r;

    logic [DATA_WIDTH-1:0]  loaded_s;
    logic [DIV_W-1:0]       div_inc_s;

    // Sample conversion applied once, when the word enters the shift register.
    function automatic logic [DATA_WIDTH-1:0] load_word(input logic [DATA_WIDTH-1:0] raw);
`ifdef FIFO_READER_OFFSET_BIN_EN
        // Flipping the sign bit maps -2^(W-1)..2^(W-1)-1 onto 0..2^W-1.
        return {~raw[DATA_WIDTH-1], raw[DATA_WIDTH-2:0]};
`else
        return raw;
`endif
    endfunction

    assign loaded_s  = load_word(data_i);
    assign div_inc_s = div_r + DIV_W'(1);

    // Frame sequencer: pop, latch, serialize, gap; all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            shift_r    <= {DATA_WIDTH{1'b0}};
            bit_cnt_r  <= {CNT_W{1'b0}};
            div_r      <= {DIV_W{1'b0}};
            rd_en_r    <= 1'b0;
            cs_n_r     <= 1'b1;
            sclk_r     <= 1'b0;
            sdo_r      <= 1'b0;
            busy_r     <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en_i && !empty_i) begin
                        state_r <= ST_POP;
                        rd_en_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        rd_en_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end

                ST_POP: begin
                    // FIFO presents the word during the following cycle.
                    state_r <= ST_LATCH;
                    rd_en_r <= 1'b0;
                    busy_r  <= 1'b1;
                end

                ST_LATCH: begin
                    state_r   <= ST_SHIFT;
                    shift_r   <= loaded_s;
                    sdo_r     <= loaded_s[DATA_WIDTH-1];
                    cs_n_r    <= 1'b0;
                    sclk_r    <= 1'b0;
                    bit_cnt_r <= {CNT_W{1'b0}};
                    div_r     <= {DIV_W{1'b0}};
                    busy_r    <= 1'b1;
                end

                ST_SHIFT: begin
                    busy_r <= 1'b1;
                    if (div_r == DIV_LAST) begin
                        // Bit period boundary: sclk drops, next bit goes out.
                        div_r  <= {DIV_W{1'b0}};
                        sclk_r <= 1'b0;
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r   <= ST_GAP;
                            cs_n_r    <= 1'b1;
                            sdo_r     <= 1'b0;
                            bit_cnt_r <= {CNT_W{1'b0}};
                        end else begin
                            state_r   <= ST_SHIFT;
                            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                            shift_r   <= {shift_r[DATA_WIDTH-2:0], 1'b0};
                            sdo_r     <= shift_r[DATA_WIDTH-2];
                        end
                    end else begin
                        // Second half of each bit period drives sclk high.
                        state_r <= ST_SHIFT;
                        div_r   <= div_inc_s;
                        sclk_r  <= (div_inc_s >= DIV_HALF);
                    end
                end

                ST_GAP: begin
                    if (en_i && !empty_i) begin
                        state_r <= ST_POP;
                        rd_en_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        rd_en_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    rd_en_r <= 1'b0;
                    cs_n_r  <= 1'b1;
                    sclk_r  <= 1'b0;
                    sdo_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase

            // Underrun is only judged at a frame boundary, never from IDLE.
            if (!en_i) begin
                underrun_r <= 1'b0;
            end else if ((state_r == ST_GAP) && empty_i) begin
                underrun_r <= 1'b1;
            end else begin
                underrun_r <= underrun_r;
            end
        end
    end

    assign rd_en_o    = rd_en_r;
    assign cs_n_o     = cs_n_r;
    assign sclk_o     = sclk_r;
    assign sdo_o      = sdo_r;
    assign busy_o     = busy_r;
    assign underrun_o = underrun_r;

endmodule

// File: tb/tb_fifo_sample_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_sample_reader
//
// Drives fifo_sample_reader from a queue-based FIFO model and decodes the DAC
// link as a receiver would: every cs_n_o low window is a frame, bits are taken
// on sclk_o rising edges and compared with the words the FIFO handed out.
// -----------------------------------------------------------------------------
module tb_fifo_sample_reader;

    localparam int W      = 16;
    localparam int DIV    = 4;
    localparam int PERIOD = 1 + 1 + W * DIV + 1;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                en_i = 1'b1;
    logic                empty_i = 1'b1;
    logic signed [W-1:0] data_i = '0;
    logic                rd_en_o, cs_n_o, sclk_o, sdo_o, busy_o, underrun_o;

    int err_cnt   = 0;
    int check_cnt = 0;

    // FIFO contents, words handed out and awaiting their frame, statistics
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    int pops = 0;
    int frames = 0;
    int cyc = 0;
    int last_pop_cyc = -1;
    int gap_cyc = -10;
    bit ur_model = 1'b0;

    fifo_sample_reader #(.DATA_WIDTH(W), .CLK_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en_i),
        .empty_i    (empty_i),
        .data_i     (data_i),
        .rd_en_o    (rd_en_o),
        .cs_n_o     (cs_n_o),
        .sclk_o     (sclk_o),
        .sdo_o      (sdo_o),
        .busy_o     (busy_o),
        .underrun_o (underrun_o)
    );

    // 10 time-unit system clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Word the DAC should receive: offset binary adds half the code range.
    function automatic logic [W-1:0] dac_word(input logic [W-1:0] d);
`ifdef FIFO_READER_OFFSET_BIN_EN
        return d + (W'(1) << (W - 1));
`else
        return d;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cs_low(input int budget);
        int k = 0;
        while (cs_n_o !== 1'b0 && k < budget) begin
            tick(1);
            k++;
        end
        check("timeout_cs_low", (k >= budget), 0);
    endtask

    task automatic wait_frames_idle(input int target, input int budget);
        int k = 0;
        while (!(frames >= target && busy_o === 1'b0) && k < budget) begin
            tick(1);
            k++;
        end
        check("timeout_frames", (k >= budget), 0);
    endtask

    // FIFO model and link receiver, evaluated mid-cycle on the falling edge.
    initial begin : monitor
        bit           prev_cs = 1'b1;
        bit           prev_sclk = 1'b0;
        bit           prev_sdo = 1'b0;
        bit           gap_now;
        int           low_cnt = 0;
        int           nbits = 0;
        logic [W-1:0] bits = '0;
        logic [W-1:0] want;
        forever begin
            @(negedge clk);
            cyc++;
            gap_now = 1'b0;

            // FIFO side: word appears the cycle after the pop; empty updates late.
            if (rd_en_o === 1'b1) begin
                check("pop_while_empty", empty_i, 0);
                check("pop_during_frame", cs_n_o, 1);
                if (gap_cyc == cyc - 1 && last_pop_cyc >= 0)
                    check("pop_period", cyc - last_pop_cyc, PERIOD);
                last_pop_cyc = cyc;
                pops++;
                if (fifo_q.size() > 0) data_i = fifo_q.pop_front();
                else data_i = W'($urandom);
                exp_q.push_back(dac_word(data_i));
            end else begin
                empty_i = (fifo_q.size() == 0);
            end

            check("underrun", underrun_o, ur_model);

            // Link receiver
            if (prev_cs && cs_n_o === 1'b0) begin
                low_cnt = 0;
                nbits = 0;
                bits = '0;
            end
            if (cs_n_o === 1'b0) begin
                low_cnt++;
                if (!prev_sclk && sclk_o === 1'b1) begin
                    bits = {bits[W-2:0], sdo_o};
                    nbits++;
                end
                if (prev_sclk && sclk_o === 1'b1 && sdo_o !== prev_sdo)
                    check("sdo_stable_sclk_high", sdo_o, prev_sdo);
            end
            if (!prev_cs && cs_n_o === 1'b1) begin
                gap_now = 1'b1;
                gap_cyc = cyc;
                frames++;
                want = (exp_q.size() > 0) ? exp_q.pop_front() : ~bits;
                check("frame_data", bits, want);
                check("frame_bits", nbits, W);
                check("cs_low_cycles", low_cnt, W * DIV);
                check("gap_sclk", sclk_o, 0);
            end

            prev_cs   = (cs_n_o !== 1'b0);
            prev_sclk = (sclk_o === 1'b1);
            prev_sdo  = sdo_o;

            // Underrun expected next cycle: set by an empty FIFO at a frame end.
            if (!rst || !en_i) ur_model = 1'b0;
            else if (gap_now && empty_i) ur_model = 1'b1;

            if (!rst) begin
                exp_q.delete();
                prev_cs   = 1'b1;
                prev_sclk = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int f0, p0;
        logic [W-1:0] rv;

        // 1. Reset and idle with an empty FIFO
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_cs_n", cs_n_o, 1);
            check("rst_sclk", sclk_o, 0);
            check("rst_rd_en", rd_en_o, 0);
            check("rst_busy", busy_o, 0);
            check("rst_underrun", underrun_o, 0);
        end
        rst = 1'b1;
        tick(5);
        check("idle_busy", busy_o, 0);
        check("idle_underrun", underrun_o, 0);
        check("idle_pops", pops, 0);

        // 2. Single frame, enable dropped before the gap
        f0 = frames; p0 = pops;
        fifo_q.push_back(16'hA5C3);
        wait_cs_low(20);
        en_i = 1'b0;
        wait_frames_idle(f0 + 1, 200);
        check("single_pops", pops - p0, 1);
        check("single_underrun", underrun_o, 0);

        // 3. Back-to-back frames, FIFO drains to empty with enable held
        f0 = frames; p0 = pops;
        fifo_q.push_back(16'h0001);
        fifo_q.push_back(16'hFFFF);
        en_i = 1'b1;
        wait_frames_idle(f0 + 2, 400);
        check("b2b_pops", pops - p0, 2);
        check("b2b_underrun_set", underrun_o, 1);
        en_i = 1'b0;
        tick(2);
        check("b2b_underrun_clr", underrun_o, 0);

        // 4. Enable dropped at bit 5: frame completes, no further pop
        f0 = frames; p0 = pops;
        fifo_q.push_back(16'h1234);
        fifo_q.push_back(16'h5555);
        en_i = 1'b1;
        wait_cs_low(20);
        tick(5 * DIV + 2);
        en_i = 1'b0;
        wait_frames_idle(f0 + 1, 200);
        tick(3);
        check("endrop_pops", pops - p0, 1);
        check("endrop_left", fifo_q.size(), 1);
        check("endrop_busy", busy_o, 0);
        check("endrop_underrun", underrun_o, 0);
        fifo_q.delete();
        tick(2);

        // 5. Reset during bit 8 aborts the frame
        rv = W'($urandom);
        fifo_q.push_back(rv);
        en_i = 1'b1;
        wait_cs_low(20);
        tick(8 * DIV + 1);
        rst = 1'b0;
        tick(1);
        check("midrst_cs_n", cs_n_o, 1);
        check("midrst_sclk", sclk_o, 0);
        check("midrst_busy", busy_o, 0);
        en_i = 1'b0;
        tick(1);
        rst = 1'b1;
        en_i = 1'b1;
        p0 = pops;
        tick(6);
        check("midrst_no_pop", pops - p0, 0);
        check("midrst_idle", busy_o, 0);

        // 6. Full-scale negative sample (sign-bit conversion visible)
        f0 = frames;
        fifo_q.push_back(16'h8000);
        wait_frames_idle(f0 + 1, 200);
        check("minval_underrun", underrun_o, 1);
        en_i = 1'b0;
        tick(2);

        // 7. Randomized pushes and enable activity
        f0 = frames; p0 = pops;
        for (int it = 0; it < 40; it++) begin
            int n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) fifo_q.push_back(W'($urandom));
            en_i = ($urandom_range(0, 3) != 0);
            tick($urandom_range(10, 150));
        end
        en_i = 1'b1;
        begin
            int k = 0;
            while (!(fifo_q.size() == 0 && busy_o === 1'b0) && k < 20000) begin
                tick(1);
                k++;
            end
            check("timeout_drain", (k >= 20000), 0);
        end
        en_i = 1'b0;
        tick(3);
        check("rand_frames_eq_pops", frames - f0, pops - p0);
        check("rand_idle", busy_o, 0);
        check("rand_underrun_clr", underrun_o, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
        $finish;
    end

endmodule
